// File: rtl/video_timing_sched.sv
// Shares one video timing generator between two frame-burst requesters:
// round-robin grant, start pulse, RGB steering, done/abort reporting and vsync watchdog.
module video_timing_sched #(
  parameter int FRAMES_W  = 16,
  parameter int WDOG_CYC  = 4096,
  parameter int RST_CYC   = 2,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                pclk,
  input  logic                rstn,
  input  logic                i_req0,
  input  logic [FRAMES_W-1:0] i_frames0,
  input  logic                i_req1,
  input  logic [FRAMES_W-1:0] i_frames1,
  input  logic [29:0]         i_rgb0,
  input  logic [29:0]         i_rgb1,
  output logic                o_gnt0,
  output logic                o_gnt1,
  output logic                o_done0,
  output logic                o_done1,
  output logic                o_err,
  output logic                o_owner,
  output logic                o_busy,
  output logic                o_tg_start,
  output logic [31:0]         o_tg_frames,
  output logic                o_tg_rstn,
  output logic [29:0]         o_tg_rgb,
  input  logic                i_tg_busy,
  input  logic                i_tg_done,
  input  logic                i_tg_vsync
);

  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  localparam int RST_W  = $clog2(RST_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RECOVER,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                busy_q, busy_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                err_q, err_d;
  logic                tg_rstn_q, tg_rstn_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [RST_W-1:0]    rcnt_q, rcnt_d;
  logic                vs_prev_q, vs_prev_d;

  logic                gnt0, gnt1, tg_start, pick, vs_int, vs_rise;
  logic [FRAMES_W-1:0] sel_frames;
  logic                tg_busy_unused;

  assign tg_busy_unused = i_tg_busy;

  assign vs_int    = i_tg_vsync ^ VSYNC_POL;
  assign vs_rise   = vs_int & ~vs_prev_q;
  assign vs_prev_d = vs_int;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    frames_d   = frames_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err_d      = 1'b0;
    wdog_d     = wdog_q;
    rcnt_d     = rcnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    tg_start   = 1'b0;
    pick       = 1'b0;
    sel_frames = '0;

    case (state_q)
      S_IDLE: begin
        if (rstn && (i_req0 || i_req1)) begin
          // With both asserted the requester that did not own last burst wins.
          pick       = (i_req0 && i_req1) ? ~last_q : i_req1;
          sel_frames = pick ? i_frames1 : i_frames0;
          gnt0       = ~pick;
          gnt1       = pick;
          owner_d    = pick;
          last_d     = pick;
          frames_d   = sel_frames;
          if (sel_frames == '0) begin
            done0_d = ~pick;
            done1_d = pick;
            busy_d  = 1'b0;
            state_d = S_GAP;
          end else begin
            busy_d  = 1'b1;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        tg_start = 1'b1;
        wdog_d   = '0;
        state_d  = S_RUN;
      end

      S_RUN: begin
        wdog_d = vs_rise ? '0 : wdog_q + 1'b1;
        if (i_tg_done) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          busy_d  = 1'b0;
          state_d = S_GAP;
        end else if (wdog_d == WDOG_LAST) begin
          rcnt_d  = '0;
          state_d = S_RECOVER;
        end
      end

      S_RECOVER: begin
        if (rcnt_q == RST_LAST) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_GAP;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end

      S_GAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The generator reset is registered so it is low for exactly the recovery cycles.
  assign tg_rstn_d = (state_d != S_RECOVER);

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      frames_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      tg_rstn_q <= 1'b0;
      wdog_q    <= '0;
      rcnt_q    <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      frames_q  <= frames_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      tg_rstn_q <= tg_rstn_d;
      wdog_q    <= wdog_d;
      rcnt_q    <= rcnt_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign o_gnt0      = gnt0;
  assign o_gnt1      = gnt1;
  assign o_done0     = done0_q;
  assign o_done1     = done1_q;
  assign o_err       = err_q;
  assign o_owner     = owner_q;
  assign o_busy      = busy_q;
  assign o_tg_start  = tg_start;
  assign o_tg_frames = 32'(frames_q);
  assign o_tg_rstn   = tg_rstn_q;
  assign o_tg_rgb    = busy_q ? (owner_q ? i_rgb1 : i_rgb0) : '0;

endmodule

// File: tb/tb_video_timing_sched.sv
// Randomized bench for video_timing_sched: bursts predicted as timelines from the
// round-robin rule, the generator's done/vsync behaviour and the watchdog budget.
module tb_video_timing_sched;

  localparam int WDOG = 64;
  localparam int RSTC = 2;

  logic        pclk = 1'b0;
  logic        rstn;
  logic        i_req0, i_req1;
  logic [15:0] i_frames0, i_frames1;
  logic [29:0] i_rgb0, i_rgb1;
  logic        o_gnt0, o_gnt1, o_done0, o_done1, o_err, o_owner, o_busy;
  logic        o_tg_start, o_tg_rstn;
  logic [31:0] o_tg_frames;
  logic [29:0] o_tg_rgb;
  logic        i_tg_busy, i_tg_done, i_tg_vsync;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_last;

  video_timing_sched #(
    .FRAMES_W (16),
    .WDOG_CYC (WDOG),
    .RST_CYC  (RSTC),
    .VSYNC_POL(1'b1)
  ) dut (
    .pclk       (pclk),
    .rstn       (rstn),
    .i_req0     (i_req0),
    .i_frames0  (i_frames0),
    .i_req1     (i_req1),
    .i_frames1  (i_frames1),
    .i_rgb0     (i_rgb0),
    .i_rgb1     (i_rgb1),
    .o_gnt0     (o_gnt0),
    .o_gnt1     (o_gnt1),
    .o_done0    (o_done0),
    .o_done1    (o_done1),
    .o_err      (o_err),
    .o_owner    (o_owner),
    .o_busy     (o_busy),
    .o_tg_start (o_tg_start),
    .o_tg_frames(o_tg_frames),
    .o_tg_rstn  (o_tg_rstn),
    .o_tg_rgb   (o_tg_rgb),
    .i_tg_busy  (i_tg_busy),
    .i_tg_done  (i_tg_done),
    .i_tg_vsync (i_tg_vsync)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    i_rgb0 = 30'($urandom);
    i_rgb1 = 30'($urandom);
  endtask

  // mode 0: done after dly cycles, no vsync; mode 1: vsync every 40 cycles, done
  // after dly cycles; mode 2: generator hangs (no vsync, no done).
  task automatic run_burst(input bit r0, input bit r1, input logic [15:0] f0,
                           input logic [15:0] f1, input int mode, input int dly);
    bit          w;
    logic [15:0] fw;
    int          last_k;
    tick();
    i_req0 = r0; i_req1 = r1; i_frames0 = f0; i_frames1 = f1;
    #1;
    w      = (r0 && r1) ? ~m_last : r1;
    m_last = w;
    fw     = w ? f1 : f0;
    chk("gnt0", o_gnt0, !w);
    chk("gnt1", o_gnt1, w);
    chk("busy_pre", o_busy, 0);
    chk("rstn_pre", o_tg_rstn, 1);
    if (fw == 0) begin
      tick(); i_req0 = 0; i_req1 = 0; #1;
      chk("zdone0", o_done0, !w);
      chk("zdone1", o_done1, w);
      chk("zerr", o_err, 0);
      chk("zstart", o_tg_start, 0);
      chk("zbusy", o_busy, 0);
    end else begin
      tick(); i_req0 = 0; i_req1 = 0; #1;
      chk("start", o_tg_start, 1);
      chk("frames", o_tg_frames, {16'h0, fw});
      chk("owner", o_owner, w);
      chk("busy", o_busy, 1);
      chk("rgb_start", o_tg_rgb, w ? i_rgb1 : i_rgb0);
      chk("gnt_start", o_gnt0 | o_gnt1, 0);
      last_k = (mode == 2) ? (WDOG - 1 + RSTC) : dly;
      for (int k = 1; k <= last_k; k++) begin
        tick();
        i_tg_busy  = 1;
        i_tg_done  = (mode != 2) && (k == dly);
        i_tg_vsync = !((mode == 1) && ((k % 40) >= 20) && ((k % 40) <= 22));
        #1;
        chk("run_busy", o_busy, 1);
        chk("run_start", o_tg_start, 0);
        chk("run_done", o_done0 | o_done1, 0);
        chk("run_rstn", o_tg_rstn, ((mode == 2) && (k >= WDOG)) ? 0 : 1);
        chk("run_rgb", o_tg_rgb, w ? i_rgb1 : i_rgb0);
      end
      tick(); i_tg_done = 0; i_tg_busy = 0; i_tg_vsync = 1; #1;
      chk("done0", o_done0, !w);
      chk("done1", o_done1, w);
      chk("err", o_err, mode == 2);
      chk("busy_end", o_busy, 0);
      chk("rgb_end", o_tg_rgb, 0);
      chk("rstn_end", o_tg_rstn, 1);
    end
    tick(); #1;
    chk("gap_done", o_done0 | o_done1, 0);
    chk("gap_gnt", o_gnt0 | o_gnt1, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pat, md, mode, dly;
    logic [15:0] f0, f1;
    rstn = 0; i_req0 = 0; i_req1 = 0; i_frames0 = 0; i_frames1 = 0;
    i_rgb0 = 0; i_rgb1 = 0; i_tg_busy = 0; i_tg_done = 0; i_tg_vsync = 1;
    repeat (3) tick();
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_owner", o_owner, 0);
    chk("rst_frames", o_tg_frames, 0);
    chk("rst_rgb", o_tg_rgb, 0);
    chk("rst_tgrstn", o_tg_rstn, 0);
    chk("rst_done", o_done0 | o_done1 | o_err, 0);
    chk("rst_start", o_tg_start, 0);
    tick(); rstn = 1; #1;
    chk("rel_tgrstn0", o_tg_rstn, 0);
    tick(); #1;
    chk("rel_tgrstn1", o_tg_rstn, 1);
    m_last = 1;

    run_burst(1, 0, 16'd3, 16'd0, 0, 5);
    repeat (4) run_burst(1, 1, 16'd1, 16'd2, 0, $urandom_range(1, 20));
    run_burst(0, 1, 16'd5, 16'd0, 0, 0);
    run_burst(1, 0, 16'd4, 16'd0, 2, 0);
    run_burst(0, 1, 16'd0, 16'd7, 1, 300);
    run_burst(1, 0, 16'd2, 16'd0, 0, WDOG - 1);

    for (int it = 0; it < 40; it++) begin
      pat  = $urandom_range(1, 3);
      md   = $urandom_range(0, 4);
      mode = (md <= 2) ? 0 : ((md == 3) ? 1 : 2);
      dly  = (mode == 0) ? $urandom_range(1, WDOG - 1) : ((mode == 1) ? $urandom_range(64, 200) : 0);
      f0   = 16'($urandom_range(0, 3));
      f1   = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        tick(); #1;
        chk("idle_gnt", o_gnt0 | o_gnt1, 0);
      end
      run_burst(pat[0], pat[1], f0, f1, mode, dly);
    end

    // Reset during a burst owned by requester 0 must restore req0 priority.
    tick(); i_req0 = 1; i_frames0 = 16'd9; #1;
    chk("mr_gnt0", o_gnt0, 1);
    tick(); i_req0 = 0; #1;
    chk("mr_start", o_tg_start, 1);
    for (int k = 0; k < 4; k++) tick();
    tick(); rstn = 0; #1;
    chk("mr_busy_pre", o_busy, 1);
    tick(); rstn = 1; #1;
    chk("mr_busy", o_busy, 0);
    chk("mr_done", o_done0 | o_done1, 0);
    chk("mr_tgrstn", o_tg_rstn, 0);
    chk("mr_gnt", o_gnt0 | o_gnt1, 0);
    m_last = 1;
    run_burst(1, 1, 16'd2, 16'd2, 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
